// File: rtl/cam_valid.sv
// Parametrised CAM with per-entry valid bits, indexed or auto-allocating writes,
// registered associative search and associative invalidate with occupancy tracking.
module cam_valid #(
    parameter int unsigned  DEPTH      = 8,
    parameter int unsigned  DATA_WIDTH = 32,
    localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            cmd,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [IDX_W-1:0]      write_idx,
    input  logic                  auto_alloc,
    output logic [IDX_W-1:0]      read_idx,
    output logic                  hit,
    output logic                  multi_hit,
    output logic [DEPTH-1:0]      match_vec,
    output logic [IDX_W-1:0]      alloc_idx,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  err
);

    localparam int unsigned IDX_SPAN = 2 ** IDX_W;

    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_SEARCH = 2'b10;
    localparam logic [1:0] CMD_INVAL  = 2'b11;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;

    logic [DEPTH-1:0]      match_c;
    logic [IDX_W-1:0]      first_c;
    logic [IDX_W-1:0]      free_c;
    logic                  has_free_c;
    logic [CNT_W-1:0]      nmatch_c;
    logic [IDX_SPAN-1:0]   idx_legal_c;

    logic                  op_write_c;
    logic                  op_search_c;
    logic                  op_inval_c;
    logic [IDX_W-1:0]      wr_idx_c;
    logic                  wr_ok_c;
    logic [DEPTH-1:0]      valid_n_c;
    logic [CNT_W-1:0]      count_n_c;

    // Match mask, lowest matching index, lowest free index and match population.
    always_comb begin
        match_c    = '0;
        first_c    = '0;
        free_c     = '0;
        has_free_c = 1'b0;
        nmatch_c   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            match_c[i] = valid[i] && (mem[i] == data);
            if (valid[i] && (mem[i] == data)) begin
                first_c  = IDX_W'(i);
                nmatch_c = nmatch_c + CNT_W'(1);
            end
            if (!valid[i]) begin
                free_c     = IDX_W'(i);
                has_free_c = 1'b1;
            end
        end
    end

    // Indices that address a real entry; only differs from all-ones for non-power-of-two DEPTH.
    always_comb begin
        idx_legal_c = '0;
        for (int unsigned j = 0; j < IDX_SPAN; j++) begin
            idx_legal_c[j] = (j < DEPTH);
        end
    end

    always_comb begin
        op_write_c  = enable && (cmd == CMD_WRITE);
        op_search_c = enable && (cmd == CMD_SEARCH);
        op_inval_c  = enable && (cmd == CMD_INVAL);
        wr_idx_c    = auto_alloc ? free_c : write_idx;
        wr_ok_c     = op_write_c && (auto_alloc ? has_free_c : idx_legal_c[write_idx]);

        valid_n_c = valid;
        count_n_c = count;
        if (wr_ok_c) begin
            valid_n_c[wr_idx_c] = 1'b1;
            if (!valid[wr_idx_c]) begin
                count_n_c = count + CNT_W'(1);
            end
        end else if (op_inval_c) begin
            valid_n_c = valid & ~match_c;
            count_n_c = count - nmatch_c;
        end
    end

    // Entry storage needs no reset: contents only matter once the valid bit is set.
    always_ff @(posedge clock) begin
        if (!reset && wr_ok_c) begin
            mem[wr_idx_c] <= data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid     <= '0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            alloc_idx <= '0;
            read_idx  <= '0;
            hit       <= 1'b0;
            multi_hit <= 1'b0;
            match_vec <= '0;
        end else begin
            valid <= valid_n_c;
            count <= count_n_c;
            full  <= (count_n_c == CNT_W'(DEPTH));
            err   <= op_write_c && !wr_ok_c;
            if (wr_ok_c) begin
                alloc_idx <= wr_idx_c;
            end
            if (op_search_c) begin
                match_vec <= match_c;
                hit       <= |match_c;
                multi_hit <= (nmatch_c >= CNT_W'(2));
                read_idx  <= first_c;
            end
        end
    end

endmodule

// File: tb/tb_cam_valid.sv
// Directed bench for cam_valid: three instances (DEPTH 8, 5 and 4) share the
// command bus and are selected by individual enables.
module tb_cam_valid;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] WR  = 2'b01;
    localparam logic [1:0] SR  = 2'b10;
    localparam logic [1:0] INV = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en8 = 1'b0, en5 = 1'b0, en4 = 1'b0;
    logic [1:0]  cmd = NOP;
    logic [31:0] data = '0;
    logic [2:0]  wi = '0;
    logic        aa = 1'b0;

    logic [2:0] ri8, ai8;  logic h8, mh8, f8, e8;  logic [7:0] mv8;  logic [3:0] c8;
    logic [2:0] ri5, ai5;  logic h5, mh5, f5, e5;  logic [4:0] mv5;  logic [2:0] c5;
    logic [1:0] ri4, ai4;  logic h4, mh4, f4, e4;  logic [3:0] mv4;  logic [2:0] c4;

    int ncmp = 0;
    int nfail = 0;

    always #5 clock = ~clock;

    cam_valid #(.DEPTH(8), .DATA_WIDTH(32)) u8 (
        .clock(clock), .reset(reset), .enable(en8), .cmd(cmd), .data(data),
        .write_idx(wi), .auto_alloc(aa), .read_idx(ri8), .hit(h8), .multi_hit(mh8),
        .match_vec(mv8), .alloc_idx(ai8), .count(c8), .full(f8), .err(e8));

    cam_valid #(.DEPTH(5), .DATA_WIDTH(32)) u5 (
        .clock(clock), .reset(reset), .enable(en5), .cmd(cmd), .data(data),
        .write_idx(wi), .auto_alloc(aa), .read_idx(ri5), .hit(h5), .multi_hit(mh5),
        .match_vec(mv5), .alloc_idx(ai5), .count(c5), .full(f5), .err(e5));

    cam_valid #(.DEPTH(4), .DATA_WIDTH(32)) u4 (
        .clock(clock), .reset(reset), .enable(en4), .cmd(cmd), .data(data),
        .write_idx(wi[1:0]), .auto_alloc(aa), .read_idx(ri4), .hit(h4), .multi_hit(mh4),
        .match_vec(mv4), .alloc_idx(ai4), .count(c4), .full(f4), .err(e4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation on the selected instance; returns 1 time unit after the edge.
    task automatic op(input int which, input logic [1:0] c, input logic [31:0] d,
                      input logic [2:0] idx, input logic a);
        en8  = (which == 8);
        en5  = (which == 5);
        en4  = (which == 4);
        cmd  = c;
        data = d;
        wi   = idx;
        aa   = a;
        @(posedge clock);
        #1;
        en8 = 1'b0;
        en5 = 1'b0;
        en4 = 1'b0;
        cmd = NOP;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #4 reset = 1'b0;
        #1;
        chk("rst8_hit", h8, 0);      chk("rst8_vec", mv8, 0);   chk("rst8_cnt", c8, 0);
        chk("rst8_full", f8, 0);     chk("rst8_err", e8, 0);    chk("rst8_alloc", ai8, 0);
        chk("rst5_cnt", c5, 0);      chk("rst4_cnt", c4, 0);    chk("rst4_full", f4, 0);

        // DEPTH=8: stale zero contents must not match invalid entries
        op(8, SR, 32'h0, 3'd0, 1'b0);
        chk("t1_hit", h8, 0);  chk("t1_vec", mv8, 0);  chk("t1_cnt", c8, 0);

        // DEPTH=8: duplicate data, priority index and multi-hit
        op(8, WR, 32'hA5, 3'd3, 1'b0);
        chk("t2_cnt1", c8, 1);  chk("t2_alloc3", ai8, 3);
        op(8, WR, 32'hA5, 3'd6, 1'b0);
        chk("t2_cnt2", c8, 2);  chk("t2_alloc6", ai8, 6);
        op(8, SR, 32'hA5, 3'd0, 1'b0);
        chk("t2_hit", h8, 1);   chk("t2_ridx", ri8, 3);  chk("t2_multi", mh8, 1);
        chk("t2_vec", mv8, 8'h48);  chk("t2_cnt", c8, 2);
        op(8, WR, 32'h1, 3'd0, 1'b0);
        chk("t2_hold_vec", mv8, 8'h48);  chk("t2_hold_hit", h8, 1);  chk("t2_cnt3", c8, 3);
        op(8, SR, 32'hA6, 3'd0, 1'b0);
        chk("t2_miss_hit", h8, 0);  chk("t2_miss_ridx", ri8, 0);
        chk("t2_miss_multi", mh8, 0);  chk("t2_miss_vec", mv8, 0);
        op(8, SR, 32'h1, 3'd0, 1'b0);
        chk("t2_single_multi", mh8, 0);  chk("t2_single_vec", mv8, 8'h01);
        op(8, INV, 32'hA5, 3'd0, 1'b0);
        chk("t2_inv2_cnt", c8, 1);  chk("t2_inv_hold_vec", mv8, 8'h01);
        op(8, INV, 32'hDEAD, 3'd0, 1'b0);
        chk("t2_invmiss_cnt", c8, 1);  chk("t2_invmiss_err", e8, 0);
        op(8, SR, 32'hA5, 3'd0, 1'b0);
        chk("t2_gone_hit", h8, 0);

        // DEPTH=5: out-of-range indexed write
        op(5, WR, 32'h55, 3'd6, 1'b0);
        chk("t3_err", e5, 1);  chk("t3_cnt0", c5, 0);
        op(0, NOP, 32'h0, 3'd0, 1'b0);
        chk("t3_err_clr", e5, 0);
        op(5, WR, 32'h55, 3'd4, 1'b0);
        chk("t3_err_ok", e5, 0);  chk("t3_cnt1", c5, 1);  chk("t3_alloc4", ai5, 4);
        chk("t3_full", f5, 0);

        // DEPTH=4: auto-allocation fills entries in index order
        for (int k = 0; k < 4; k++) begin
            op(4, WR, 32'h10 + 32'(k), 3'd3, 1'b1);
            chk("t4_alloc", ai4, 64'(k));
            chk("t4_cnt", c4, 64'(k + 1));
        end
        chk("t4_full", f4, 1);
        op(4, WR, 32'h20, 3'd0, 1'b1);
        chk("t4_err", e4, 1);  chk("t4_cnt4", c4, 4);  chk("t4_alloc_hold", ai4, 3);

        // DEPTH=4: invalidate frees a hole that auto-allocation reuses
        op(4, INV, 32'h11, 3'd0, 1'b0);
        chk("t5_cnt3", c4, 3);  chk("t5_full0", f4, 0);  chk("t5_err", e4, 0);
        op(4, WR, 32'h99, 3'd0, 1'b1);
        chk("t5_alloc1", ai4, 1);  chk("t5_cnt4", c4, 4);  chk("t5_full1", f4, 1);
        op(4, SR, 32'h11, 3'd0, 1'b0);
        chk("t5_hit0", h4, 0);
        op(4, SR, 32'h99, 3'd0, 1'b0);
        chk("t5_hit99", h4, 1);  chk("t5_ridx99", ri4, 1);  chk("t5_vec99", mv4, 4'b0010);

        // DEPTH=4: overwrite of a valid entry, then asynchronous reset mid-cycle
        op(4, WR, 32'h77, 3'd2, 1'b0);
        chk("t6_cnt", c4, 4);  chk("t6_alloc2", ai4, 2);  chk("t6_err", e4, 0);
        op(4, SR, 32'h77, 3'd0, 1'b0);
        chk("t6_hit", h4, 1);  chk("t6_ridx", ri4, 2);  chk("t6_vec", mv4, 4'b0100);
        op(4, SR, 32'h12, 3'd0, 1'b0);
        chk("t6_old_hit", h4, 0);
        op(4, SR, 32'h77, 3'd0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("t6_ar_hit", h4, 0);   chk("t6_ar_vec", mv4, 0);   chk("t6_ar_ridx", ri4, 0);
        chk("t6_ar_cnt", c4, 0);   chk("t6_ar_full", f4, 0);   chk("t6_ar_alloc", ai4, 0);
        chk("t6_ar_cnt8", c8, 0);  chk("t6_ar_cnt5", c5, 0);
        #1 reset = 1'b0;
        op(4, SR, 32'h77, 3'd0, 1'b0);
        chk("t6_post_hit", h4, 0);  chk("t6_post_vec", mv4, 0);  chk("t6_post_cnt", c4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/cam_valid.md
Name: cam_valid

Overview:
- Parametrised content-addressable memory with a per-entry valid bit and selectable data width and depth; DEPTH need not be a power of two.
- Supports indexed write, auto-allocating write, associative search and associative invalidate.
- Search results are registered and report priority index, full match vector and multi-hit.
- Occupancy tracking (count/full) lets a producer use it as a tag store or free-list front end.

Parameters:
DEPTH, 8, number of entries (any value >= 2)
DATA_WIDTH, 32, width of stored/compared data
IDX_W, max(1,$clog2(DEPTH)), index width (derived, not overridden)
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
enable  input  1  operation strobe; when 0 the cycle is a NOP
cmd  input  2  00 NOP, 01 WRITE, 10 SEARCH, 11 INVALIDATE
data  input  DATA_WIDTH  write data / search key / invalidate key
write_idx  input  IDX_W  target entry for indexed WRITE
auto_alloc  input  1  WRITE goes to lowest-index invalid entry; write_idx ignored
read_idx  output  IDX_W  lowest matching valid index from last SEARCH
hit  output  1  last SEARCH matched at least one valid entry
multi_hit  output  1  last SEARCH matched two or more valid entries
match_vec  output  DEPTH  per-entry match mask from last SEARCH
alloc_idx  output  IDX_W  entry written by last successful WRITE
count  output  CNT_W  number of valid entries
full  output  1  count == DEPTH
err  output  1  one-cycle pulse: rejected WRITE

Behaviour:
- Reset (async): all valid bits 0; count 0; full 0.
- Reset clears read_idx, hit, multi_hit, match_vec, alloc_idx and err to 0.
- Entry data contents are don't-care after reset.
- Reset asserted mid-operation aborts that operation with no state change.
- One operation per cycle, sampled at the rising edge when enable=1. enable=0 or cmd=NOP changes nothing except clearing err.
- WRITE, indexed (auto_alloc=0):
  - write_idx < DEPTH: entry := data, valid := 1, alloc_idx := write_idx.
  - count increments only if the entry was previously invalid.
  - write_idx >= DEPTH (non-power-of-two DEPTH): no state change, err=1 next cycle.
- WRITE, auto (auto_alloc=1):
  - Selects the lowest-index invalid entry, writes data, sets valid, alloc_idx := that index, count+1.
  - If full: dropped, err=1 next cycle, alloc_idx holds.
- Duplicate data in multiple entries is permitted.
- SEARCH:
  - Compares data against all entries; only valid entries can match.
  - One cycle after the op: match_vec = mask, hit = |mask, multi_hit = popcount(mask) >= 2, read_idx = lowest set bit.
  - On miss: read_idx = 0, hit = 0, multi_hit = 0.
  - Search outputs hold until the next SEARCH or reset; WRITE/INVALIDATE do not disturb them.
- INVALIDATE:
  - Clears the valid bit of every valid entry equal to data.
  - count decreases by the number cleared.
  - No match: no effect, no err.
- count/full update on the same edge as the operation.
- err is asserted only in the cycle following a rejected WRITE.
- Unused cmd/enable combinations: none; all four encodings are defined.

Test Plan:
1. Reset, then SEARCH 0x0 -> hit=0, match_vec=0, count=0 (stale zero data must not match invalid entries).
2. DEPTH=8: indexed WRITE 0xA5 to idx 3 and 0xA5 to idx 6, then SEARCH 0xA5 -> next cycle hit=1, read_idx=3, multi_hit=1, match_vec=0x48, count=2.
3. DEPTH=5: indexed WRITE to idx 6 -> err=1 for exactly one cycle, count unchanged; WRITE to idx 4 -> err=0, count=1.
4. DEPTH=4: four auto_alloc WRITEs of 0x10..0x13 -> alloc_idx 0,1,2,3, full=1; fifth auto WRITE -> err=1, count stays 4.
5. With DEPTH=4 full, INVALIDATE 0x11 -> count=3, full=0; next auto WRITE 0x99 -> alloc_idx=1; SEARCH 0x11 -> hit=0.
6. Overwrite idx 2 (valid, 0x12) with 0x77 -> count unchanged. Assert reset asynchronously between edges -> all outputs 0 immediately, and a subsequent SEARCH 0x77 misses.
